// File: rtl/ins_fetch_pkg.sv
// Shared fetch-stage types: widths, default words, FSM state codes.
// Imported by ins_fetch and ifid_reg.
package ins_fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] HALT_DEF = 32'hFFFF_FFFF;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: ins, pc4, valid with hold and squash.
// Ports: clk, rst_n, hold, squash, insIn/pc4In/validIn -> ins/pc4/valid.
module ifid_reg
  import ins_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              squash,
  input  logic [WORD_W-1:0] insIn,
  input  logic [ADDR_W-1:0] pc4In,
  input  logic              validIn,
  output logic [WORD_W-1:0] ins,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  // squash wins over hold; pc4 is left as-is on a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins   <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (squash) begin
      ins   <= NOP_WORD;
      valid <= 1'b0;
    end else if (!hold) begin
      ins   <= insIn;
      pc4   <= pc4In;
      valid <= validIn;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC, BOOT/RUN/HOLD/HALT FSM, IF/ID register.
// Ports: redirects (br/jmp), stall, pc_out/ins_in memory, ifid_*, halted.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [WORD_W-1:0] NOP_WORD  = NOP_DEF,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [WORD_W-1:0] ins_in,
  output logic [WORD_W-1:0] ifid_ins,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              halted
);

  logic [1:0]        state;
  logic [1:0]        stateNxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNxt;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              hold;
  logic              squash;
  logic              validIn;

  assign pcPlus4  = pc + 8'd4;
  assign redirect = br_taken | jmp;
  assign target   = (br_taken ? br_target : jmp_target)
                  & 8'hFC;

  // ins_in is only looked at on a real capture,
  // so X on it elsewhere never reaches state
  always_comb begin
    stateNxt = state;
    pcNxt    = pc;
    hold     = 1'b1;
    squash   = 1'b0;
    validIn  = 1'b0;
    unique case (state)
      BOOT: stateNxt = RUN;
      HALT: stateNxt = HALT;
      RUN, HOLD: begin
        if (redirect) begin
          pcNxt    = target;
          squash   = 1'b1;
          stateNxt = RUN;
        end else if (stall) begin
          stateNxt = HOLD;
        end else begin
          hold = 1'b0;
          if (ins_in == HALT_WORD) begin
            stateNxt = HALT;
          end else begin
            validIn  = 1'b1;
            pcNxt    = pcPlus4;
            stateNxt = RUN;
          end
        end
      end
      default: stateNxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= stateNxt;
      pc    <= pcNxt;
    end
  end

  ifid_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .squash (squash),
    .insIn  (ins_in),
    .pc4In  (pcPlus4),
    .validIn(validIn),
    .ins    (ifid_ins),
    .pc4    (ifid_pc4),
    .valid  (ifid_valid)
  );

  assign pc_out = pc;
  assign halted = (state == HALT);

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: byte memory model, per-edge expectations.
// Expected pc/ifid/halted values are queued before each edge and popped after.
module tb_ins_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        jmp;
  logic [7:0]  jmp_target;
  logic [7:0]  pc_out;
  logic [31:0] ins_in;
  logic [31:0] ifid_ins;
  logic [7:0]  ifid_pc4;
  logic        ifid_valid;
  logic        halted;

  logic [7:0] mem [256];
  logic [7:0] a1, a2, a3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [7:0]  pc;
    logic        v;
    logic [31:0] ins;
    logic [7:0]  pc4;
    logic        pc4Chk;
    logic        h;
  } exp_t;

  exp_t sb[$];

  ins_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .pc_out    (pc_out),
    .ins_in    (ins_in),
    .ifid_ins  (ifid_ins),
    .ifid_pc4  (ifid_pc4),
    .ifid_valid(ifid_valid),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a1 = pc_out + 8'd1;
  assign a2 = pc_out + 8'd2;
  assign a3 = pc_out + 8'd3;
  assign ins_in = {mem[pc_out], mem[a1], mem[a2], mem[a3]};

  function automatic logic [31:0] w(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {a, b1, b2, b3};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmpAll(input exp_t e);
    check({e.tag, ".pc"}, {24'h0, pc_out}, {24'h0, e.pc});
    check({e.tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.v});
    check({e.tag, ".ins"}, ifid_ins, e.ins);
    if (e.pc4Chk)
      check({e.tag, ".pc4"}, {24'h0, ifid_pc4}, {24'h0, e.pc4});
    check({e.tag, ".halted"}, {31'h0, halted}, {31'h0, e.h});
  endtask

  task automatic step(input string tag,
                      input logic s, input logic b, input logic [7:0] bt,
                      input logic j, input logic [7:0] jt,
                      input logic [7:0] ePc, input logic eV,
                      input logic [31:0] eIns, input logic [7:0] ePc4,
                      input logic eChk, input logic eH);
    exp_t e;
    stall      = s;
    br_taken   = b;
    br_target  = bt;
    jmp        = j;
    jmp_target = jt;
    e.tag = tag; e.pc = ePc; e.v = eV; e.ins = eIns;
    e.pc4 = ePc4; e.pc4Chk = eChk; e.h = eH;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      cmpAll(sb.pop_front());
    end
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    for (int i = 16; i < 20; i++) mem[i] = 8'hFF;
    rst_n = 1'b0;
    stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
    r.tag = "rst"; r.pc = 8'h00; r.v = 0; r.ins = 32'h0;
    r.pc4 = 8'h00; r.pc4Chk = 1; r.h = 0;
    #2;
    cmpAll(r);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("boot", 0,0,8'h00,0,8'h00, 8'h00,0,32'h0,     8'h00,1,0);
    step("f00",  0,0,8'h00,0,8'h00, 8'h04,1,w(8'h00),  8'h04,1,0);
    step("f04",  0,0,8'h00,0,8'h00, 8'h08,1,w(8'h04),  8'h08,1,0);
    for (int i = 0; i < 3; i++)
      step("stall",1,0,8'h00,0,8'h00, 8'h08,1,w(8'h04), 8'h08,1,0);
    step("f08",  0,0,8'h00,0,8'h00, 8'h0C,1,w(8'h08),  8'h0C,1,0);
    step("brst", 1,1,8'h23,0,8'h00, 8'h20,0,32'h0,     8'h00,0,0);
    step("f20",  0,0,8'h00,0,8'h00, 8'h24,1,w(8'h20),  8'h24,1,0);
    step("jmpFC",0,0,8'h00,1,8'hFD, 8'hFC,0,32'h0,     8'h00,0,0);
    step("fFC",  0,0,8'h00,0,8'h00, 8'h00,1,w(8'hFC),  8'h00,1,0);
    step("prio", 0,1,8'h41,1,8'h80, 8'h40,0,32'h0,     8'h00,0,0);
    step("f40",  0,0,8'h00,0,8'h00, 8'h44,1,w(8'h40),  8'h44,1,0);
    step("hold", 1,0,8'h00,0,8'h00, 8'h44,1,w(8'h40),  8'h44,1,0);
    step("jmpHd",1,0,8'h00,1,8'h10, 8'h10,0,32'h0,     8'h00,0,0);
    step("halt", 0,0,8'h00,0,8'h00, 8'h10,0,32'hFFFFFFFF,8'h14,1,1);
    step("hJmp", 1,0,8'h00,1,8'h40, 8'h10,0,32'hFFFFFFFF,8'h14,1,1);
    step("hBr",  0,1,8'h80,0,8'h00, 8'h10,0,32'hFFFFFFFF,8'h14,1,1);
    step("hIdle",0,0,8'h00,0,8'h00, 8'h10,0,32'hFFFFFFFF,8'h14,1,1);

    #3 rst_n = 1'b0;
    #1;
    r.tag = "rstHalt";
    cmpAll(r);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("boot2",0,0,8'h00,0,8'h00, 8'h00,0,32'h0,     8'h00,1,0);
    step("f00b", 0,0,8'h00,0,8'h00, 8'h04,1,w(8'h00),  8'h04,1,0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
